// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU MEM-stage port, EXT requester port
// and the single-port data-memory side, seen from the arbiter (slave) or its environment (master).
interface dmem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_read;
   logic          cpu_write;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;

   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic          ext_gnt;
   logic [DW-1:0] ext_rdata;
   logic          ext_rvalid;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_write;
   logic          mem_read;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
      output cpu_rdata, cpu_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_read, cpu_write,
      input  cpu_rdata, cpu_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_addr, mem_wdata, mem_write, mem_read,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and an external
// requester; CPU has priority, EXT gets a bounded forced burst after MAX_WAIT blocked cycles.
module dmem_arbiter #(
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   dmem_arbiter_if.slave        bus,
   output logic [15:0]          stall_count
);
   typedef enum logic {CPU_OWN, EXT_OWN} state_t;

   localparam int WW = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
   localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

   state_t        state_reg;
   logic [WW-1:0] wait_cnt_reg;
   logic [BW-1:0] burst_cnt_reg;
   logic          ext_rvalid_reg;
   logic [DW-1:0] ext_rdata_reg;
   logic [15:0]   stall_count_reg;

   logic cpu_active;
   logic cpu_sel;
   logic ext_sel;
   logic stall_int;

   // Owner select; reset forces the memory and both handshakes idle.
   always_comb begin
      cpu_active = bus.cpu_read | bus.cpu_write;
      cpu_sel    = 1'b0;
      ext_sel    = 1'b0;
      if (!reset) begin
         if (state_reg == EXT_OWN) begin
            ext_sel = bus.ext_req;
            cpu_sel = ~bus.ext_req & cpu_active;
         end else begin
            cpu_sel = cpu_active;
            ext_sel = ~cpu_active & bus.ext_req;
         end
      end
      stall_int = ext_sel & cpu_active;
   end

   assign bus.ext_gnt    = ext_sel;
   assign bus.cpu_stall  = stall_int;
   assign bus.mem_addr   = ext_sel ? bus.ext_addr  : bus.cpu_addr;
   assign bus.mem_wdata  = ext_sel ? bus.ext_wdata : bus.cpu_wdata;
   assign bus.mem_write  = ext_sel ? bus.ext_we    : (cpu_sel & bus.cpu_write);
   assign bus.mem_read   = ext_sel ? ~bus.ext_we   : (cpu_sel & bus.cpu_read & ~bus.cpu_write);
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.ext_rdata  = ext_rdata_reg;
   assign bus.ext_rvalid = ext_rvalid_reg;
   assign stall_count    = stall_count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= CPU_OWN;
         wait_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
      end else begin
         case (state_reg)
            CPU_OWN: begin
               if (bus.ext_req & cpu_active) begin
                  if (wait_cnt_reg == WAIT_LAST) begin
                     state_reg     <= EXT_OWN;
                     wait_cnt_reg  <= '0;
                     burst_cnt_reg <= '0;
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + WW'(1);
                  end
               end else begin
                  wait_cnt_reg <= '0;
               end
            end
            EXT_OWN: begin
               // The last grant of a burst still happens; ownership returns after it.
               if (!bus.ext_req || burst_cnt_reg == BURST_LAST) begin
                  state_reg     <= CPU_OWN;
                  wait_cnt_reg  <= '0;
                  burst_cnt_reg <= '0;
               end else begin
                  burst_cnt_reg <= burst_cnt_reg + BW'(1);
               end
            end
            default: state_reg <= CPU_OWN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ext_rvalid_reg  <= 1'b0;
         ext_rdata_reg   <= '0;
         stall_count_reg <= '0;
      end else begin
         ext_rvalid_reg <= ext_sel & ~bus.ext_we;
         if (ext_sel & ~bus.ext_we) begin
            ext_rdata_reg <= bus.mem_rdata;
         end
         if (stall_int && stall_count_reg != 16'hFFFF) begin
            stall_count_reg <= stall_count_reg + 16'd1;
         end
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline's MEM stage (CPU port) and an external requester, such as a program loader or debug port (EXT port).
- One memory access per cycle. The CPU has priority by default.
- A wait counter with a forced-ownership burst guarantees the EXT port forward progress; the pipeline is held off with cpu_stall.
- Sits between the processor's dmem* ports and the data memory.

Parameters:
AW, 16, address width
DW, 16, data width
MAX_WAIT, 4, consecutive blocked EXT cycles before EXT takes forced ownership (>=1)
BURST_MAX, 8, max consecutive EXT-owned cycles per forced burst (>=1)

Ports:
clock  in  1  system clock, posedge
reset  in  1  synchronous, active-high
cpu_addr  in  AW  MEM-stage address
cpu_wdata  in  DW  MEM-stage write data
cpu_read  in  1  MEM-stage read enable
cpu_write  in  1  MEM-stage write enable
cpu_rdata  out  DW  read data to pipeline (combinational)
cpu_stall  out  1  pipeline must hold MEM stage and upstream
ext_req  in  1  EXT access request, held until granted
ext_we  in  1  1=write, 0=read; valid with ext_req
ext_addr  in  AW  EXT address
ext_wdata  in  DW  EXT write data
ext_gnt  out  1  EXT access performed this cycle (combinational)
ext_rdata  out  DW  registered EXT read data
ext_rvalid  out  1  ext_rdata valid, one cycle after a granted read
mem_addr  out  AW  to data memory
mem_wdata  out  DW  to data memory
mem_write  out  1  to data memory
mem_read  out  1  to data memory
mem_rdata  in  DW  from data memory, asynchronous read (same cycle)
stall_count  out  16  saturating count of cycles with cpu_stall=1

Behaviour:
Reset state:
- state=CPU_OWN, wait_cnt=0, burst_cnt=0.
- ext_rvalid=0, ext_rdata=0, stall_count=0.
- While reset=1: cpu_stall=0, ext_gnt=0, mem_write=0, mem_read=0.

Definitions and common rules:
- cpu_active = cpu_read | cpu_write.
- If cpu_read and cpu_write are both 1, the access is a write and mem_read=0. The same rule applies to the EXT port via ext_we.
- Exactly one owner drives mem_* each cycle. If no access is performed, mem_read=mem_write=0 and mem_addr/mem_wdata are don't-care.

CPU_OWN:
- If cpu_active: mem_* follow cpu_*, cpu_stall=0, ext_gnt=0.
- Else if ext_req: mem_* follow ext_*, ext_gnt=1 (opportunistic grant).
- wait_cnt:
  - increments when ext_req & cpu_active;
  - clears when ext_gnt=1 or ext_req=0.
- When ext_req & cpu_active & wait_cnt==MAX_WAIT-1: next state EXT_OWN, burst_cnt=0, wait_cnt=0.

EXT_OWN:
- If ext_req: mem_* follow ext_*, ext_gnt=1.
- cpu_stall=cpu_active. A stalled CPU access is not performed and must be re-presented.
- burst_cnt increments on each grant.
- Return to CPU_OWN (wait_cnt=0) when:
  - ext_req=0 in this state (no access, cpu_stall=0 that cycle, CPU access performed), or
  - the grant at burst_cnt==BURST_MAX-1 completes (that grant still happens).
- After a forced burst the CPU owns memory for at least MAX_WAIT cycles.

EXT read return:
- On a granted EXT read, ext_rdata<=mem_rdata and ext_rvalid<=1 at the next posedge.
- ext_rvalid is otherwise 0 (single-cycle pulse per read).
- Back-to-back granted reads give back-to-back rvalid pulses.

Latency:
- CPU access in CPU_OWN: 0 added cycles.
- EXT request is granted within MAX_WAIT cycles of assertion, given a continuously busy CPU.

stall_count:
- Increments every cycle cpu_stall=1.
- Saturates at 16'hFFFF.

Reset asserted mid-burst:
- Returns to CPU_OWN next cycle.
- An in-flight ext_rvalid is dropped (0).

Test Plan:
1. CPU only: cpu_write addr 0x0010 data 0x1234, then cpu_read 0x0010 -> mem_write=1 same cycle; cpu_rdata=0x1234; cpu_stall=0 throughout; stall_count=0.
2. Idle-CPU EXT read: mem[0x0020]=0xBEEF, ext_req=1 ext_we=0 ext_addr=0x0020 with cpu idle -> ext_gnt=1 same cycle; next cycle ext_rvalid=1, ext_rdata=0xBEEF.
3. Starvation: cpu_read held 1 continuously, ext_req=1 writing 0x5555 -> ext_gnt=0 for 4 cycles; ext_gnt=1 and cpu_stall=1 in cycle 5; stall_count increments.
4. Burst limit: CPU busy and EXT always requesting, MAX_WAIT=4, BURST_MAX=8 -> repeating pattern of 4 CPU cycles then 8 EXT grants; stall_count=8 after the first burst.
5. Early burst end: ext_req drops after 3 forced grants -> next cycle state CPU_OWN, cpu_stall=0, CPU access performed.
6. Conflict and reset: cpu_read=cpu_write=1 -> mem_read=0, mem_write=1. Reset asserted mid-burst -> next cycle ext_gnt=0, cpu_stall=0, ext_rvalid=0, stall_count=0.
